code_entry_checker: RTL and testbench

//   Upstream stage of the unlock register. Collects keypad digits one at a time
//   and compares them against a stored code. Emits a one-cycle verdict strobe:
//   out_en drives the register's in_en, out_data drives its in_data.

---
 rtl/code_entry_checker_if.sv | 20 ++
 rtl/code_entry_checker.sv | 130 +++++++++++++
 tb/tb_code_entry_checker.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/code_entry_checker_if.sv
// Keypad-side inputs and verdict/status outputs of the code entry checker.
interface code_entry_checker_if;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       key_clear;
   logic       out_data;
   logic       out_en;
   logic       out_lockout;
   logic [2:0] out_count;

   modport master (
      output key_valid, key_digit, key_clear,
      input  out_data, out_en, out_lockout, out_count
   );

   modport slave (
      input  key_valid, key_digit, key_clear,
      output out_data, out_en, out_lockout, out_count
   );
endinterface

// File: rtl/code_entry_checker.sv
// Collects keypad digits, compares them with a stored code and emits a one-cycle
// verdict strobe; repeated failures lock entry out for a fixed number of cycles.
module code_entry_checker #(
   parameter int unsigned CODE_LEN    = 4,
   parameter logic [27:0] CODE        = 28'h1234,
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned LOCK_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 clr_n,
   code_entry_checker_if.slave  bus
);

   localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

   localparam logic [2:0]        LAST_IDX    = 3'(CODE_LEN - 1);
   localparam logic [15:0]       LOCK_RELOAD = 16'(LOCK_CYCLES - 1);
   localparam logic [FAIL_W-1:0] FAIL_LIMIT  = FAIL_W'(MAX_FAIL);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] LOCKOUT = 2'd2;

   logic [1:0]        state,      state_nxt;
   logic [2:0]        cnt,        cnt_nxt;
   logic              mismatch,   mismatch_nxt;
   logic [FAIL_W-1:0] fail_cnt,   fail_cnt_nxt;
   logic [15:0]       timer,      timer_nxt;
   logic              data_q,     data_nxt;
   logic              en_q,       en_nxt;
   logic              lockout_q,  lockout_nxt;

   logic [2:0]        digit_idx;
   logic [3:0]        exp_digit;
   logic              digit_bad;
   logic [FAIL_W-1:0] fail_inc;

   assign bus.out_data    = data_q;
   assign bus.out_en      = en_q;
   assign bus.out_lockout = lockout_q;
   assign bus.out_count   = cnt;

   // Expected digit: first digit entered is the most-significant nibble.
   always_comb begin
      digit_idx = LAST_IDX - cnt;
      exp_digit = CODE[{digit_idx, 2'b00} +: 4];
      digit_bad = (bus.key_digit != exp_digit);
      fail_inc  = fail_cnt + FAIL_W'(1);
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      mismatch_nxt = mismatch;
      fail_cnt_nxt = fail_cnt;
      timer_nxt    = timer;
      data_nxt     = data_q;
      en_nxt       = 1'b0;
      lockout_nxt  = lockout_q;

      case (state)
         IDLE, COLLECT: begin
            if (bus.key_clear) begin
               cnt_nxt      = 3'd0;
               mismatch_nxt = 1'b0;
               state_nxt    = IDLE;
            end else if (bus.key_valid) begin
               if (cnt == LAST_IDX) begin
                  en_nxt       = 1'b1;
                  data_nxt     = ~(mismatch | digit_bad);
                  cnt_nxt      = 3'd0;
                  mismatch_nxt = 1'b0;
                  state_nxt    = IDLE;
                  if (!(mismatch | digit_bad)) begin
                     fail_cnt_nxt = '0;
                  end else if (fail_inc == FAIL_LIMIT) begin
                     state_nxt    = LOCKOUT;
                     lockout_nxt  = 1'b1;
                     timer_nxt    = LOCK_RELOAD;
                     fail_cnt_nxt = '0;
                  end else begin
                     fail_cnt_nxt = fail_inc;
                  end
               end else begin
                  cnt_nxt      = cnt + 3'd1;
                  mismatch_nxt = mismatch | digit_bad;
                  state_nxt    = COLLECT;
               end
            end
         end
         // Keys are ignored; timer==0 means this is the last locked cycle.
         LOCKOUT: begin
            if (timer == 16'd0) begin
               state_nxt   = IDLE;
               lockout_nxt = 1'b0;
            end else begin
               timer_nxt = timer - 16'd1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            cnt_nxt     = 3'd0;
            lockout_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         mismatch  <= 1'b0;
         fail_cnt  <= '0;
         timer     <= 16'd0;
         data_q    <= 1'b0;
         en_q      <= 1'b0;
         lockout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         mismatch  <= mismatch_nxt;
         fail_cnt  <= fail_cnt_nxt;
         timer     <= timer_nxt;
         data_q    <= data_nxt;
         en_q      <= en_nxt;
         lockout_q <= lockout_nxt;
      end
   end

endmodule

// File: tb/tb_code_entry_checker.sv
// Directed bench for code_entry_checker with a short lockout (8 cycles).
module tb_code_entry_checker;

   logic clk;
   logic clr_n;
   int   total;
   int   bad;

   code_entry_checker_if bus ();

   code_entry_checker #(
      .CODE_LEN   (4),
      .CODE       (28'h1234),
      .MAX_FAIL   (3),
      .LOCK_CYCLES(8)
   ) dut (
      .clk  (clk),
      .clr_n(clr_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   // Drive one cycle of inputs at a falling edge, return at the next falling edge.
   task automatic step(input logic v, input logic [3:0] d, input logic c);
      bus.key_valid = v;
      bus.key_digit = d;
      bus.key_clear = c;
      @(negedge clk);
      bus.key_valid = 1'b0;
      bus.key_clear = 1'b0;
   endtask

   task automatic enter_code(input logic [15:0] code);
      step(1'b1, code[15:12], 1'b0);
      step(1'b1, code[11:8],  1'b0);
      step(1'b1, code[7:4],   1'b0);
      step(1'b1, code[3:0],   1'b0);
   endtask

   task automatic test_reset;
      clr_n         = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_digit = 4'd0;
      bus.key_clear = 1'b0;
      #12;
      total++;
      if ({bus.out_data, bus.out_en, bus.out_lockout, bus.out_count} !== 6'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 000000",
                  {bus.out_data, bus.out_en, bus.out_lockout, bus.out_count});
      end
      @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_correct;
      step(1'b1, 4'd1, 1'b0);
      total++;
      if (bus.out_count !== 3'd1) begin
         bad++; $display("FAIL correct_count1: got %0d want 1", bus.out_count);
      end
      step(1'b1, 4'd2, 1'b0);
      step(1'b1, 4'd3, 1'b0);
      total++;
      if (bus.out_count !== 3'd3) begin
         bad++; $display("FAIL correct_count3: got %0d want 3", bus.out_count);
      end
      step(1'b1, 4'd4, 1'b0);
      total++;
      if ({bus.out_en, bus.out_data, bus.out_count} !== 5'b11_000) begin
         bad++; $display("FAIL correct_verdict: got en,data,count=%b want 11000",
                         {bus.out_en, bus.out_data, bus.out_count});
      end
      step(1'b0, 4'd0, 1'b0);
      total++;
      if ({bus.out_en, bus.out_data} !== 2'b01) begin
         bad++; $display("FAIL correct_pulse_end: got en,data=%b want 01",
                         {bus.out_en, bus.out_data});
      end
   endtask

   task automatic test_wrong;
      enter_code(16'h1294);
      total++;
      if ({bus.out_en, bus.out_data, bus.out_lockout} !== 3'b100) begin
         bad++; $display("FAIL wrong_verdict: got en,data,lock=%b want 100",
                         {bus.out_en, bus.out_data, bus.out_lockout});
      end
      step(1'b0, 4'd0, 1'b0);
      enter_code(16'h1234);
      total++;
      if ({bus.out_en, bus.out_data} !== 2'b11) begin
         bad++; $display("FAIL wrong_then_right: got en,data=%b want 11",
                         {bus.out_en, bus.out_data});
      end
      step(1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_lockout;
      enter_code(16'h5555);
      step(1'b0, 4'd0, 1'b0);
      enter_code(16'h12A4);
      total++;
      if ({bus.out_en, bus.out_data, bus.out_lockout} !== 3'b100) begin
         bad++; $display("FAIL lock_second_fail: got en,data,lock=%b want 100",
                         {bus.out_en, bus.out_data, bus.out_lockout});
      end
      step(1'b0, 4'd0, 1'b0);
      enter_code(16'h4321);
      total++;
      if ({bus.out_en, bus.out_data, bus.out_lockout} !== 3'b101) begin
         bad++; $display("FAIL lock_third_fail: got en,data,lock=%b want 101",
                         {bus.out_en, bus.out_data, bus.out_lockout});
      end
      // 7 more locked cycles, keys pressed throughout must be ignored.
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 4'd1, 1'b0);
         total++;
         if ({bus.out_lockout, bus.out_en, bus.out_count} !== 5'b10_000) begin
            bad++; $display("FAIL lock_hold[%0d]: got lock,en,count=%b want 10000",
                            i, {bus.out_lockout, bus.out_en, bus.out_count});
         end
      end
      step(1'b1, 4'd1, 1'b0);
      total++;
      if ({bus.out_lockout, bus.out_count} !== 4'b0_000) begin
         bad++; $display("FAIL lock_release: got lock,count=%b want 0000",
                         {bus.out_lockout, bus.out_count});
      end
      enter_code(16'h1234);
      total++;
      if ({bus.out_en, bus.out_data, bus.out_lockout} !== 3'b110) begin
         bad++; $display("FAIL lock_after_unlock: got en,data,lock=%b want 110",
                         {bus.out_en, bus.out_data, bus.out_lockout});
      end
      step(1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_clear;
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd2, 1'b0);
      step(1'b1, 4'd3, 1'b1);
      total++;
      if ({bus.out_en, bus.out_count} !== 4'b0_000) begin
         bad++; $display("FAIL clear_abort: got en,count=%b want 0000",
                         {bus.out_en, bus.out_count});
      end
      step(1'b0, 4'd0, 1'b0);
      total++;
      if (bus.out_en !== 1'b0) begin
         bad++; $display("FAIL clear_no_verdict: got en=%b want 0", bus.out_en);
      end
      enter_code(16'h1234);
      total++;
      if ({bus.out_en, bus.out_data} !== 2'b11) begin
         bad++; $display("FAIL clear_then_right: got en,data=%b want 11",
                         {bus.out_en, bus.out_data});
      end
      step(1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_async_reset;
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd2, 1'b0);
      #2 clr_n = 1'b0;
      #1;
      total++;
      if ({bus.out_data, bus.out_en, bus.out_lockout, bus.out_count} !== 6'b0) begin
         bad++; $display("FAIL areset_collect: got %b want 000000",
                         {bus.out_data, bus.out_en, bus.out_lockout, bus.out_count});
      end
      @(negedge clk);
      clr_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         enter_code(16'h9999);
         step(1'b0, 4'd0, 1'b0);
      end
      step(1'b0, 4'd0, 1'b0);
      total++;
      if (bus.out_lockout !== 1'b1) begin
         bad++; $display("FAIL areset_lock_entry: got lock=%b want 1", bus.out_lockout);
      end
      #2 clr_n = 1'b0;
      #1;
      total++;
      if ({bus.out_data, bus.out_en, bus.out_lockout, bus.out_count} !== 6'b0) begin
         bad++; $display("FAIL areset_lockout: got %b want 000000",
                         {bus.out_data, bus.out_en, bus.out_lockout, bus.out_count});
      end
      @(negedge clk);
      clr_n = 1'b1;
      enter_code(16'h1234);
      total++;
      if ({bus.out_en, bus.out_data, bus.out_lockout} !== 3'b110) begin
         bad++; $display("FAIL areset_no_retain: got en,data,lock=%b want 110",
                         {bus.out_en, bus.out_data, bus.out_lockout});
      end
      step(1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_back_to_back;
      logic [3:0] seq [8];
      int first_pulse;
      int second_pulse;
      int pulses;
      seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd3, 4'd4};
      first_pulse  = -1;
      second_pulse = -1;
      pulses       = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, seq[i], 1'b0);
         if (bus.out_en === 1'b1) begin
            pulses++;
            if (first_pulse < 0) first_pulse = i; else second_pulse = i;
            total++;
            if (bus.out_data !== 1'b1) begin
               bad++; $display("FAIL b2b_data[%0d]: got %b want 1", i, bus.out_data);
            end
         end
      end
      total++;
      if (pulses != 2 || first_pulse != 3 || second_pulse != 7) begin
         bad++; $display("FAIL b2b_pulses: got n=%0d at %0d,%0d want n=2 at 3,7",
                         pulses, first_pulse, second_pulse);
      end
      step(1'b0, 4'd0, 1'b0);
      total++;
      if ({bus.out_en, bus.out_count} !== 4'b0_000) begin
         bad++; $display("FAIL b2b_idle: got en,count=%b want 0000",
                         {bus.out_en, bus.out_count});
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_correct();
      test_wrong();
      test_lockout();
      test_clear();
      test_async_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
